// File: rtl/simon_key_loader_pkg.sv
// Shared types and register map constants for the Simon key loader.
package simon_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WB,
        ST,
        RA,
        RD,
        FIN
    } key_fsm_e;

    // Byte offset of the start-override register inside simon_cfg
    localparam int unsigned SIMON_CFG_START_OFS  = 'h20;
    // Byte stride between consecutive key words
    localparam int unsigned SIMON_CFG_WORD_BYTES = 4;

endpackage

// File: rtl/simon_key_loader_axil_wr_beat.sv
// Single-beat AXI4-Lite write engine: one req pulse issues AW+W, then waits for B.
// addr_done pulses when both AW and W have been accepted; ack pulses with the B beat.
module simon_axil_wr_beat #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned PROT_WIDTH = 1,
    parameter int unsigned RESP_WIDTH = 2,
    parameter int unsigned STRB_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  addr_done,
    output logic                  ack,
    output logic [RESP_WIDTH-1:0] resp,
    output logic [ADDR_WIDTH-1:0] m_awaddr,
    output logic [PROT_WIDTH-1:0] m_awprot,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [DATA_WIDTH-1:0] m_wdata,
    output logic [STRB_WIDTH-1:0] m_wstrb,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    input  logic [RESP_WIDTH-1:0] m_bresp,
    input  logic                  m_bvalid,
    output logic                  m_bready
);

    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  bready_q, bready_d;
    logic                  aw_hs, w_hs;

    // Next-state for the AW/W valids (each drops on its own ready) and B ready
    always_comb begin
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        aw_hs     = awvalid_q & m_awready;
        w_hs      = wvalid_q & m_wready;
        addr_done = (awvalid_q | wvalid_q) & (aw_hs | ~awvalid_q) & (w_hs | ~wvalid_q);
        ack       = bready_q & m_bvalid;
        resp      = m_bresp;
        if (ack) begin
            bready_d = 1'b0;
        end
        if (req) begin
            awaddr_d  = addr;
            wdata_d   = data;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
        end else begin
            if (aw_hs) awvalid_d = 1'b0;
            if (w_hs)  wvalid_d  = 1'b0;
            if (addr_done) bready_d = 1'b1;
        end
    end

    // Channel registers
    always_ff @(posedge clk) begin
        if (rst) begin
            awaddr_q  <= '0;
            wdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
        end else begin
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
        end
    end

    assign m_awaddr  = awaddr_q;
    assign m_awprot  = '0;
    assign m_awvalid = awvalid_q;
    assign m_wdata   = wdata_q;
    assign m_wstrb   = '1;
    assign m_wvalid  = wvalid_q;
    assign m_bready  = bready_q;

endmodule

// File: rtl/simon_key_loader.sv
// Simon key loader: programs a full key into simon_cfg over AXI4-Lite,
// optionally writes the start override, then reports done/err.
// Optional feature: define SIMON_KEY_READBACK_EN to read every key word back
// and flag any response error or data mismatch.
module simon_key_loader
    import simon_pkg::*;
#(
    parameter int unsigned KEYLEN_BYTES   = 32,
    parameter int unsigned CFG_DATA_WIDTH = 32,
    parameter int unsigned CFG_ADDR_WIDTH = 32,
    parameter int unsigned CFG_PROT_WIDTH = 1,
    parameter int unsigned CFG_RESP_WIDTH = 2,
    parameter int unsigned CFG_STRB_WIDTH = 4,
    parameter logic [CFG_ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter int unsigned SEND_START     = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [KEYLEN_BYTES*8-1:0] load_key,
    input  logic                      load_valid,
    output logic                      load_ready,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [CFG_ADDR_WIDTH-1:0] m_awaddr,
    output logic [CFG_PROT_WIDTH-1:0] m_awprot,
    output logic                      m_awvalid,
    input  logic                      m_awready,
    output logic [CFG_DATA_WIDTH-1:0] m_wdata,
    output logic [CFG_STRB_WIDTH-1:0] m_wstrb,
    output logic                      m_wvalid,
    input  logic                      m_wready,
    input  logic [CFG_RESP_WIDTH-1:0] m_bresp,
    input  logic                      m_bvalid,
    output logic                      m_bready,
    output logic [CFG_ADDR_WIDTH-1:0] m_araddr,
    output logic [CFG_PROT_WIDTH-1:0] m_arprot,
    output logic                      m_arvalid,
    input  logic                      m_arready,
    input  logic [CFG_DATA_WIDTH-1:0] m_rdata,
    input  logic [CFG_RESP_WIDTH-1:0] m_rresp,
    input  logic                      m_rvalid,
    output logic                      m_rready
);

    localparam int unsigned KEY_W  = KEYLEN_BYTES * 8;
    localparam int unsigned NWORDS = KEY_W / CFG_DATA_WIDTH;
    localparam int unsigned IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    function automatic logic [CFG_ADDR_WIDTH-1:0] word_addr(input logic [IDX_W-1:0] i);
        return BASE_ADDR + CFG_ADDR_WIDTH'(i) * CFG_ADDR_WIDTH'(SIMON_CFG_WORD_BYTES);
    endfunction

    function automatic logic [CFG_DATA_WIDTH-1:0] key_word(input logic [KEY_W-1:0] k,
                                                           input logic [IDX_W-1:0] i);
        return k[int'(i)*CFG_DATA_WIDTH +: CFG_DATA_WIDTH];
    endfunction

    key_fsm_e             state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [KEY_W-1:0]     key_q, key_d;
    logic                 err_acc_q, err_acc_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 writes_end, go_fin;

    logic                      eng_req, eng_addr_done, eng_ack;
    logic [CFG_ADDR_WIDTH-1:0] eng_addr;
    logic [CFG_DATA_WIDTH-1:0] eng_data;
    logic [CFG_RESP_WIDTH-1:0] eng_resp;

`ifdef SIMON_KEY_READBACK_EN
    logic [CFG_ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic                      arvalid_q, arvalid_d;
    logic                      rready_q, rready_d;
`endif

    simon_axil_wr_beat #(
        .ADDR_WIDTH (CFG_ADDR_WIDTH),
        .DATA_WIDTH (CFG_DATA_WIDTH),
        .PROT_WIDTH (CFG_PROT_WIDTH),
        .RESP_WIDTH (CFG_RESP_WIDTH),
        .STRB_WIDTH (CFG_STRB_WIDTH)
    ) u_wr_beat (
        .clk       (clk),
        .rst       (rst),
        .req       (eng_req),
        .addr      (eng_addr),
        .data      (eng_data),
        .addr_done (eng_addr_done),
        .ack       (eng_ack),
        .resp      (eng_resp),
        .m_awaddr  (m_awaddr),
        .m_awprot  (m_awprot),
        .m_awvalid (m_awvalid),
        .m_awready (m_awready),
        .m_wdata   (m_wdata),
        .m_wstrb   (m_wstrb),
        .m_wvalid  (m_wvalid),
        .m_wready  (m_wready),
        .m_bresp   (m_bresp),
        .m_bvalid  (m_bvalid),
        .m_bready  (m_bready)
    );

    // Sequencer next-state: the write engine is kicked on the same cycle the FSM
    // enters WR/ST, so its valids are up in the first cycle of that state
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        key_d      = key_q;
        err_acc_d  = err_acc_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        eng_req    = 1'b0;
        eng_addr   = '0;
        eng_data   = '0;
        writes_end = 1'b0;
        go_fin     = 1'b0;
`ifdef SIMON_KEY_READBACK_EN
        araddr_d  = araddr_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
`endif
        case (state_q)
            IDLE: begin
                if (load_valid) begin
                    key_d    = load_key;
                    idx_d    = '0;
                    state_d  = WR;
                    eng_req  = 1'b1;
                    eng_addr = word_addr('0);
                    eng_data = key_word(load_key, '0);
                end
            end
            WR: begin
                if (eng_addr_done) state_d = WB;
            end
            WB: begin
                if (eng_ack) begin
                    err_acc_d = err_acc_q | (|eng_resp);
                    if (idx_q != LAST_IDX) begin
                        idx_d    = idx_q + 1'b1;
                        state_d  = WR;
                        eng_req  = 1'b1;
                        eng_addr = word_addr(idx_q + 1'b1);
                        eng_data = key_word(key_q, idx_q + 1'b1);
                    end else if (SEND_START != 0) begin
                        state_d  = ST;
                        eng_req  = 1'b1;
                        eng_addr = BASE_ADDR + CFG_ADDR_WIDTH'(SIMON_CFG_START_OFS);
                        eng_data = '0;
                    end else begin
                        writes_end = 1'b1;
                    end
                end
            end
            ST: begin
                if (eng_ack) begin
                    err_acc_d  = err_acc_q | (|eng_resp);
                    writes_end = 1'b1;
                end
            end
`ifdef SIMON_KEY_READBACK_EN
            RA: begin
                if (m_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD;
                end
            end
            RD: begin
                if (m_rvalid) begin
                    err_acc_d = err_acc_q | (|m_rresp) | (m_rdata != key_word(key_q, idx_q));
                    rready_d  = 1'b0;
                    if (idx_q != LAST_IDX) begin
                        idx_d     = idx_q + 1'b1;
                        arvalid_d = 1'b1;
                        araddr_d  = word_addr(idx_q + 1'b1);
                        state_d   = RA;
                    end else begin
                        go_fin = 1'b1;
                    end
                end
            end
`endif
            FIN: begin
                err_acc_d = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (writes_end) begin
`ifdef SIMON_KEY_READBACK_EN
            idx_d     = '0;
            arvalid_d = 1'b1;
            araddr_d  = word_addr('0);
            state_d   = RA;
`else
            go_fin = 1'b1;
`endif
        end
        if (go_fin) begin
            state_d = FIN;
            done_d  = 1'b1;
            err_d   = err_acc_d;
        end
    end

    // Sequencer registers with registered done/err
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            key_q     <= '0;
            err_acc_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef SIMON_KEY_READBACK_EN
            araddr_q  <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            key_q     <= key_d;
            err_acc_q <= err_acc_d;
            done_q    <= done_d;
            err_q     <= err_d;
`ifdef SIMON_KEY_READBACK_EN
            araddr_q  <= araddr_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
`endif
        end
    end

    assign load_ready = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign err        = err_q;
    assign m_arprot   = '0;

`ifdef SIMON_KEY_READBACK_EN
    assign m_araddr  = araddr_q;
    assign m_arvalid = arvalid_q;
    assign m_rready  = rready_q;
`else
    logic unused_rd_ports;
    assign unused_rd_ports = ^{m_arready, m_rdata, m_rresp, m_rvalid};
    assign m_araddr  = '0;
    assign m_arvalid = 1'b0;
    assign m_rready  = 1'b0;
`endif

endmodule

// File: tb/tb_simon_key_loader.sv
// Bench for simon_key_loader: randomized keys and slave latencies against a
// write-list reference model and a register-image stand-in for simon_cfg.
module tb_simon_key_loader;

    localparam int KEY_W = 256;
    localparam int NW    = 8;
    localparam int NWR   = NW + 1;

    logic           clk = 1'b0;
    logic           rst;
    logic [KEY_W-1:0] load_key;
    logic           load_valid;
    logic           load_ready, busy, done, err;
    logic [31:0]    m_awaddr, m_wdata, m_araddr, m_rdata;
    logic [0:0]     m_awprot, m_arprot;
    logic [3:0]     m_wstrb;
    logic           m_awvalid, m_awready, m_wvalid, m_wready;
    logic [1:0]     m_bresp, m_rresp;
    logic           m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;

    always #5 clk = ~clk;

    simon_key_loader dut (
        .clk(clk), .rst(rst),
        .load_key(load_key), .load_valid(load_valid), .load_ready(load_ready),
        .busy(busy), .done(done), .err(err),
        .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    // ---------------- AXI4-Lite slave model (simon_cfg stand-in) ----------------
    int          aw_dly = 0, w_dly = 0, ar_dly = 0;
    int          aw_wait, w_wait, ar_wait;
    int          beats, b_tot;
    int          err_beat = -1;
    bit          corrupt = 1'b0;
    logic        aw_have, w_have, r_pend;
    logic [31:0] aw_hold, w_hold, r_addr;
    logic        bvalid_r, rvalid_r;
    logic [1:0]  bresp_r;
    logic [31:0] rdata_r;
    logic [31:0] cfg_mem [0:7];
    logic [31:0] aw_log[$], w_log[$], ar_log[$];

    logic        aw_hs, w_hs, aw_got, w_got;
    logic [31:0] addr_cur, data_cur;

    assign m_awready = m_awvalid && (aw_wait >= aw_dly);
    assign m_wready  = m_wvalid && (w_wait >= w_dly);
    assign m_arready = m_arvalid && (ar_wait >= ar_dly);
    assign m_bvalid  = bvalid_r;
    assign m_bresp   = bresp_r;
    assign m_rvalid  = rvalid_r;
    assign m_rdata   = rdata_r;
    assign m_rresp   = 2'b00;
    assign aw_hs     = m_awvalid & m_awready;
    assign w_hs      = m_wvalid & m_wready;
    assign aw_got    = aw_have | aw_hs;
    assign w_got     = w_have | w_hs;
    assign addr_cur  = aw_hs ? m_awaddr : aw_hold;
    assign data_cur  = w_hs ? m_wdata : w_hold;

    always @(posedge clk) begin
        if (rst) begin
            aw_wait <= 0; w_wait <= 0; ar_wait <= 0;
            beats <= 0; b_tot <= 0;
            aw_have <= 1'b0; w_have <= 1'b0; r_pend <= 1'b0;
            bvalid_r <= 1'b0; rvalid_r <= 1'b0; bresp_r <= 2'b00; rdata_r <= '0;
        end else begin
            if (m_awvalid) aw_wait <= m_awready ? 0 : aw_wait + 1;
            if (m_wvalid)  w_wait  <= m_wready ? 0 : w_wait + 1;
            if (m_arvalid) ar_wait <= m_arready ? 0 : ar_wait + 1;
            if (aw_hs) aw_log.push_back(m_awaddr);
            if (w_hs)  w_log.push_back(m_wdata);
            if (aw_got && w_got) begin
                if (addr_cur < 32'h20) cfg_mem[addr_cur[4:2]] <= data_cur;
                aw_have <= 1'b0;
                w_have  <= 1'b0;
                beats   <= beats + 1;
            end else begin
                if (aw_hs) begin aw_have <= 1'b1; aw_hold <= m_awaddr; end
                if (w_hs)  begin w_have  <= 1'b1; w_hold  <= m_wdata;  end
            end
            if (bvalid_r) begin
                if (m_bready) begin bvalid_r <= 1'b0; b_tot <= b_tot + 1; end
            end else if (beats > b_tot && $urandom_range(0, 2) != 0) begin
                bvalid_r <= 1'b1;
                bresp_r  <= (b_tot == err_beat) ? 2'b10 : 2'b00;
            end
            if (m_arvalid && m_arready) begin
                ar_log.push_back(m_araddr);
                r_pend <= 1'b1;
                r_addr <= m_araddr;
            end
            if (rvalid_r) begin
                if (m_rready) rvalid_r <= 1'b0;
            end else if (r_pend && $urandom_range(0, 2) != 0) begin
                rvalid_r <= 1'b1;
                r_pend   <= 1'b0;
                rdata_r  <= cfg_mem[r_addr[4:2]] ^ ((corrupt && r_addr[4:2] == 3'd2) ? 32'd1 : 32'd0);
            end
        end
    end

    // ---------------- Protocol / event monitor ----------------
    int          cyc = 0, done_cnt = 0, done_cyc = 0, acc_cnt = 0, acc_cyc = 0, stab_err = 0;
    logic        aw_stall, w_stall;
    logic [31:0] aw_prev, w_prev;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (done) begin done_cnt <= done_cnt + 1; done_cyc <= cyc; end
        if (!rst && load_valid && load_ready) begin acc_cnt <= acc_cnt + 1; acc_cyc <= cyc; end
        if (!rst && aw_stall && (!m_awvalid || m_awaddr != aw_prev)) stab_err <= stab_err + 1;
        if (!rst && w_stall && (!m_wvalid || m_wdata != w_prev)) stab_err <= stab_err + 1;
        aw_stall <= !rst && m_awvalid && !m_awready;
        w_stall  <= !rst && m_wvalid && !m_wready;
        aw_prev  <= m_awaddr;
        w_prev   <= m_wdata;
    end

    // ---------------- Checking ----------------
    int n_tests = 0, n_fail = 0;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [KEY_W-1:0] rand_key();
        logic [KEY_W-1:0] k;
        for (int i = 0; i < NW; i++) k[32*i +: 32] = $urandom();
        return k;
    endfunction

    task automatic send_key(input logic [KEY_W-1:0] k);
        int n = 0;
        @(negedge clk);
        load_key   = k;
        load_valid = 1'b1;
        while (!load_ready && n < 2000) begin @(negedge clk); n++; end
        check_eq("accept_timeout", load_ready, 1'b1);
        @(posedge clk);
        #1 load_valid = 1'b0;
    endtask

    task automatic wait_done(output logic e);
        int n = 0;
        e = 1'bx;
        @(negedge clk);
        while (!done && n < 3000) begin @(negedge clk); n++; end
        check_eq("done_timeout", done, 1'b1);
        e = err;
        @(negedge clk);
        check_eq("done_one_cycle", done, 1'b0);
    endtask

    // Reference: the write list a key must produce and the resulting cfg image
    task automatic run_key(input string tag, input logic [KEY_W-1:0] k, input logic exp_err);
        logic e;
        logic [KEY_W-1:0] img;
        aw_log.delete(); w_log.delete(); ar_log.delete();
        send_key(k);
        wait_done(e);
        repeat (3) @(negedge clk);
        check_eq({tag, "_err"}, e, exp_err);
        check_eq({tag, "_naw"}, aw_log.size(), NWR);
        check_eq({tag, "_nw"}, w_log.size(), NWR);
        for (int i = 0; i < NWR && i < aw_log.size() && i < w_log.size(); i++) begin
            check_eq($sformatf("%s_awaddr%0d", tag, i), aw_log[i], (i < NW) ? 32'(4*i) : 32'h20);
            check_eq($sformatf("%s_wdata%0d", tag, i), w_log[i], (i < NW) ? k[32*i +: 32] : 32'h0);
        end
        for (int i = 0; i < NW; i++) img[32*i +: 32] = cfg_mem[i];
        check_eq({tag, "_cfg_key"}, img, k);
`ifdef SIMON_KEY_READBACK_EN
        check_eq({tag, "_nar"}, ar_log.size(), NW);
        for (int i = 0; i < NW && i < ar_log.size(); i++)
            check_eq($sformatf("%s_araddr%0d", tag, i), ar_log[i], 32'(4*i));
`else
        check_eq({tag, "_nar"}, ar_log.size(), 0);
`endif
        check_eq({tag, "_idle"}, load_ready, 1'b1);
    endtask

    initial begin
        logic [KEY_W-1:0] ka, kb;
        int n, d0;
        rst = 1'b1; load_valid = 1'b0; load_key = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_valids", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 5'b0);
        check_eq("rst_done_busy", {done, busy}, 2'b0);
        check_eq("rst_load_ready", load_ready, 1'b1);
        check_eq("rst_addr_data", {m_awaddr, m_wdata, m_araddr}, 96'b0);
        rst = 1'b0;

        // 1: fixed key 0x1f1e..0100, always-ready slave
        for (int i = 0; i < 32; i++) ka[8*i +: 8] = 8'(i);
        run_key("t1", ka, 1'b0);
        check_eq("t1_strb_prot", {m_wstrb, m_awprot}, 5'b11110);

        // 2: AW delayed 3, W immediate
        aw_dly = 3; w_dly = 0;
        run_key("t2", rand_key(), 1'b0);

        // 2b: random slave latencies
        for (int t = 0; t < 4; t++) begin
            aw_dly = $urandom_range(0, 4); w_dly = $urandom_range(0, 4); ar_dly = $urandom_range(0, 3);
            run_key($sformatf("t2r%0d", t), rand_key(), 1'b0);
        end
        aw_dly = 0; w_dly = 0; ar_dly = 0;

        // 3: error response on word 5, then a clean key
        @(negedge clk);
        err_beat = b_tot + 5;
        run_key("t3", rand_key(), 1'b1);
        err_beat = -1;
        run_key("t3_next", rand_key(), 1'b0);

        // 4: reset while waiting on B of word 3
        aw_log.delete();
        d0 = done_cnt;
        send_key(rand_key());
        n = 0;
        while (!(m_bready && aw_log.size() == 4) && n < 2000) begin @(negedge clk); n++; end
        check_eq("t4_reach_wb3", m_bready, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("t4_valids", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 5'b0);
        check_eq("t4_busy_ready", {busy, load_ready}, 2'b01);
        check_eq("t4_no_done", done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("t4_done_cnt", done_cnt, d0);
        run_key("t4_after", rand_key(), 1'b0);

`ifdef SIMON_KEY_READBACK_EN
        // 5: readback with word 2 corrupted
        corrupt = 1'b1;
        run_key("t5", rand_key(), 1'b1);
        corrupt = 1'b0;
`endif

        // 6: load_valid held high across two keys
        aw_log.delete(); w_log.delete();
        ka = rand_key(); kb = rand_key();
        d0 = done_cnt;
        n = acc_cnt;
        @(negedge clk);
        load_key = ka; load_valid = 1'b1;
        while (acc_cnt < n + 1 && cyc < 90000) @(negedge clk);
        load_key = kb;
        while (acc_cnt < n + 2 && cyc < 90000) @(negedge clk);
        check_eq("t6_second_accept", acc_cnt, n + 2);
        check_eq("t6_accept_after_done", acc_cyc, done_cyc + 1);
        check_eq("t6_done_between", done_cnt, d0 + 1);
        @(posedge clk);
        #1 load_valid = 1'b0;
        while (done_cnt < d0 + 2 && cyc < 90000) @(negedge clk);
        repeat (3) @(negedge clk);
        check_eq("t6_done_total", done_cnt, d0 + 2);
        check_eq("t6_aw_beats", aw_log.size(), 2 * NWR);
        for (int i = 0; i < NW; i++) ka[32*i +: 32] = cfg_mem[i];
        check_eq("t6_cfg_key", ka, kb);

        check_eq("aw_w_stability", stab_err, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute run bound
    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
